// File: rtl/pipe_latch_elastic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_latch_elastic_pkg
// Description : Shared types and constants for the elastic pipeline latch.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_latch_elastic_pkg;

    localparam int PIPE_LATCH_MAX_DEPTH = 8;

    typedef logic [31:0] pstat_t;

    localparam pstat_t C_PSTAT_MAX = 32'hFFFF_FFFF;

    // Handshake outcome of one cycle, {push, pop}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } pl_op_e;

    // Circular increment that also wraps correctly for non-power-of-2 depths
    function automatic int unsigned ptr_next(input int unsigned p, input int unsigned depth);
        return (p + 1 >= depth) ? 0 : p + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_latch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_latch_ctrl
// Description : Pointer/occupancy control for the elastic pipeline latch.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_latch_ctrl
    import pipe_latch_elastic_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PW    = 1,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_in_valid,
    input  logic          i_out_ready,
    input  logic          i_flush,
    output logic          o_push,
    output logic [PW-1:0] o_wr_ptr,
    output logic [PW-1:0] o_rd_ptr,
    output logic [CW-1:0] o_count,
    output logic          o_in_ready,
    output logic          o_out_valid
);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;
    pl_op_e        w_op;

    // Handshake readiness depends only on registered occupancy
    assign o_in_ready  = (r_count != CW'(DEPTH));
    assign o_out_valid = (r_count != '0);

    assign w_push = i_in_valid  & o_in_ready  & ~i_flush;
    assign w_pop  = o_out_valid & i_out_ready & ~i_flush;
    assign w_op   = pl_op_e'({w_push, w_pop});

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= PW'(ptr_next(int'(r_wr_ptr), DEPTH));
            end
            if (w_pop) begin
                r_rd_ptr <= PW'(ptr_next(int'(r_rd_ptr), DEPTH));
            end
            case (w_op)
                OP_PUSH: r_count <= r_count + 1'b1;
                OP_POP:  r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_push   = w_push;
    assign o_wr_ptr = r_wr_ptr;
    assign o_rd_ptr = r_rd_ptr;
    assign o_count  = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_latch_elastic.sv
`default_nettype none
// ============================================================================
// Module      : pipe_latch_elastic
// Description : Elastic valid/ready pipeline stage register, DEPTH entries,
//               zero payload when empty. PIPE_LATCH_STATS_EN adds stall and
//               bubble cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_latch_elastic
    import pipe_latch_elastic_pkg::*;
#(
    parameter  int DWIDTH = 32,
    parameter  int DEPTH  = 2,
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    input  logic              flush,
    output logic [CW-1:0]     count,
    output pstat_t            stall_cnt,
    output pstat_t            bubble_cnt
);

    generate
        if (DEPTH < 1 || DEPTH > PIPE_LATCH_MAX_DEPTH || DWIDTH < 1) begin : g_bad_param
            $error("pipe_latch_elastic: unsupported DEPTH/DWIDTH");
        end
    endgenerate

    logic              w_push;
    logic [PW-1:0]     w_wr_ptr;
    logic [PW-1:0]     w_rd_ptr;
    logic              w_in_ready;
    logic              w_out_valid;
    logic [DWIDTH-1:0] r_mem [DEPTH];

    pipe_latch_ctrl #(
        .DEPTH (DEPTH),
        .PW    (PW),
        .CW    (CW)
    ) u_ctrl (
        .clk         (CLK),
        .rst         (RST),
        .i_in_valid  (in_valid),
        .i_out_ready (out_ready),
        .i_flush     (flush),
        .o_push      (w_push),
        .o_wr_ptr    (w_wr_ptr),
        .o_rd_ptr    (w_rd_ptr),
        .o_count     (count),
        .o_in_ready  (w_in_ready),
        .o_out_valid (w_out_valid)
    );

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= in_data;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    // Empty stage presents an all-zero NOP bubble downstream
    assign out_data  = w_out_valid ? r_mem[w_rd_ptr] : '0;

`ifdef PIPE_LATCH_STATS_EN
    pstat_t r_stall_cnt;
    pstat_t r_bubble_cnt;

    // Only reset clears the statistics; flush leaves them intact
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (in_valid && !w_in_ready && (r_stall_cnt != C_PSTAT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (out_ready && !w_out_valid && (r_bubble_cnt != C_PSTAT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = 32'd0;
    assign bubble_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_latch_elastic.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_latch_elastic
// Description : Scoreboard bench for pipe_latch_elastic (DEPTH=2 and DEPTH=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_latch_elastic;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        a_in_valid = 1'b0, a_out_ready = 1'b0, a_flush = 1'b0;
    logic [31:0] a_in_data = '0;
    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data, a_stall, a_bubble;
    logic [1:0]  a_count;

    logic        b_in_valid = 1'b0, b_out_ready = 1'b0, b_flush = 1'b0;
    logic [31:0] b_in_data = '0;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data, b_stall, b_bubble;
    logic [1:0]  b_count;

    int errors = 0;
    int checks = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    always #5 clk = ~clk;

    pipe_latch_elastic #(.DWIDTH(32), .DEPTH(2)) dut_a (
        .CLK(clk), .RST(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .flush(a_flush), .count(a_count),
        .stall_cnt(a_stall), .bubble_cnt(a_bubble)
    );

    pipe_latch_elastic #(.DWIDTH(32), .DEPTH(3)) dut_b (
        .CLK(clk), .RST(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .flush(b_flush), .count(b_count),
        .stall_cnt(b_stall), .bubble_cnt(b_bubble)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every accepted output beat is compared against the queue head
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready && !a_flush) begin
            if (q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected: got 0x%08h expected no output", a_out_data);
            end else begin
                chk("a_out_data", a_out_data, q_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready && !b_flush) begin
            if (q_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected: got 0x%08h expected no output", b_out_data);
            end else begin
                chk("b_out_data", b_out_data, q_b.pop_front());
            end
        end
    end

    initial begin
        int model_cnt;
        int v;
        int cyc;
        logic m_push, m_pop;

        // 1. reset then pass-through
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data", a_out_data, 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        a_in_valid = 1'b1; a_in_data = 32'hA5A5_0001; a_out_ready = 1'b1;
        q_a.push_back(32'hA5A5_0001);
        step();
        a_in_valid = 1'b0;
        chk("pt_out_valid", 32'(a_out_valid), 32'd1);
        chk("pt_out_data", a_out_data, 32'hA5A5_0001);
        step();
        chk("pt_count_after_pop", 32'(a_count), 32'd0);

        // 2. fill and backpressure
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'h11; q_a.push_back(32'h11); step();
        a_in_data = 32'h22; q_a.push_back(32'h22); step();
        a_in_data = 32'h33;
        chk("full_count", 32'(a_count), 32'd2);
        chk("full_in_ready", 32'(a_in_ready), 32'd0);
        step();
        chk("full_no_accept", 32'(a_count), 32'd2);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        step();
        chk("bp_in_ready_after_pop", 32'(a_in_ready), 32'd1);
        chk("bp_count_1", 32'(a_count), 32'd1);
        step();
        chk("bp_count_0", 32'(a_count), 32'd0);

        // 3. simultaneous push+pop at count=1
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'h100; q_a.push_back(32'h100); step();
        a_out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            a_in_data = 32'h100 + 32'(i);
            q_a.push_back(a_in_data);
            step();
            chk("pp_count", 32'(a_count), 32'd1);
        end
        a_in_valid = 1'b0;
        step();
        chk("pp_drain", 32'(a_count), 32'd0);

        // 4. flush while full with concurrent push; then RST with flush
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'h44; q_a.push_back(32'h44); step();
        a_in_data = 32'h55; q_a.push_back(32'h55); step();
        a_flush = 1'b1; a_in_data = 32'hDEAD; a_out_ready = 1'b1;
        step();
        q_a.delete();
        a_flush = 1'b0; a_in_valid = 1'b0;
        chk("fl_count", 32'(a_count), 32'd0);
        chk("fl_out_valid", 32'(a_out_valid), 32'd0);
        chk("fl_out_data", a_out_data, 32'd0);
        step();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'h66; q_a.push_back(32'h66); step();
        a_in_data = 32'h77; q_a.push_back(32'h77); step();
        rst = 1'b1; a_flush = 1'b1; a_in_data = 32'hBEEF;
        step();
        q_a.delete();
        rst = 1'b0; a_flush = 1'b0; a_in_valid = 1'b0;
        chk("rf_count", 32'(a_count), 32'd0);
        chk("rf_out_valid", 32'(a_out_valid), 32'd0);
        chk("rf_out_data", a_out_data, 32'd0);

        // 5. DEPTH=3 wrap with random out_ready, tracked by an occupancy model
        for (int i = 1; i <= 7; i++) q_b.push_back(32'(i));
        model_cnt = 0; v = 1; cyc = 0;
        while ((v <= 7 || model_cnt != 0) && cyc < 200) begin
            b_in_valid  = (v <= 7);
            b_in_data   = 32'(v);
            b_out_ready = (v <= 7) ? 1'($urandom_range(0, 1)) : 1'b1;
            m_push = b_in_valid && (model_cnt != 3);
            m_pop  = (model_cnt != 0) && b_out_ready;
            step();
            if (m_push) begin model_cnt++; v++; end
            if (m_pop) model_cnt--;
            chk("wrap_count", 32'(b_count), 32'(model_cnt));
            cyc++;
        end
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        if (cyc >= 200) begin
            checks++; errors++;
            $display("FAIL wrap_timeout: got %0d cycles expected < 200", cyc);
        end

        // 6. statistics counters
        rst = 1'b1; a_out_ready = 1'b0; a_in_valid = 1'b0;
        step();
        rst = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'h61; q_a.push_back(32'h61); step();
        a_in_data = 32'h62; q_a.push_back(32'h62); step();
        a_in_data = 32'h63;
        repeat (5) step();
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        repeat (5) step();
        a_out_ready = 1'b0;
`ifdef PIPE_LATCH_STATS_EN
        chk("stall_cnt", a_stall, 32'd5);
        chk("bubble_cnt", a_bubble, 32'd3);
`else
        chk("stall_cnt_tied", a_stall, 32'd0);
        chk("bubble_cnt_tied", a_bubble, 32'd0);
`endif
        a_flush = 1'b1; step(); a_flush = 1'b0;
`ifdef PIPE_LATCH_STATS_EN
        chk("stall_cnt_flush", a_stall, 32'd5);
        chk("bubble_cnt_flush", a_bubble, 32'd3);
`else
        chk("stall_cnt_tied_flush", a_stall, 32'd0);
        chk("bubble_cnt_tied_flush", a_bubble, 32'd0);
`endif

        step(); step();
        chk("a_queue_left", 32'(q_a.size()), 32'd0);
        chk("b_queue_left", 32'(q_b.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
